node_integrator_sat: RTL and testbench



---
 rtl/node_integrator_sat.sv | 199 +++++++++++++++++++
 tb/tb_node_integrator_sat.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_integrator_sat.sv
// Saturating node integrator: sums N signed branch currents, integrates them into a clamped node voltage, and tracks settling/oscillation.
// Optional build macro NODE_LEAK_EN: zero net current bleeds the node toward 0 by one LSB per enabled cycle.
module node_integrator_sat #(
   parameter int W             = 8,
   parameter int N             = 4,
   parameter int VHI           = 64,
   parameter int VLO           = -64,
   parameter int CAP_SHIFT     = 0,
   parameter int SETTLE_CYCLES = 3,
   parameter int MAX_ITER      = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                load,
   input  logic signed [W-1:0] load_v,
   input  logic [N*W-1:0]      i_flat,
   output logic signed [W-1:0] v,
   output logic                level,
   output logic                settled,
   output logic                osc,
   output logic                changed,
   output logic [1:0]          dbg_state
);

   localparam int SW = W + $clog2(N);
   localparam int QW = $clog2(SETTLE_CYCLES + 1);
   localparam int IW = $clog2(MAX_ITER + 1);

   localparam logic signed [SW-1:0] SUM_MAX = SW'((2 ** (W - 1)) - 1);
   localparam logic signed [SW-1:0] SUM_MIN = SW'(-(2 ** (W - 1)));
   localparam logic signed [W:0]    V_HI    = (W + 1)'(VHI);
   localparam logic signed [W:0]    V_LO    = (W + 1)'(VLO);
   localparam logic [QW-1:0]        Q_DONE  = QW'(SETTLE_CYCLES);
   localparam logic [IW-1:0]        I_MAX   = IW'(MAX_ITER);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_QUIET   = 2'd1,
      S_SETTLED = 2'd2
   } state_t;

   state_t                state_q;
   logic signed [W-1:0]   v_q;
   logic [QW-1:0]         quiet_q;
   logic [IW-1:0]         iter_q;
   logic                  settled_q;
   logic                  osc_q;
   logic                  changed_q;

   logic signed [SW-1:0]  sum_raw;
   logic signed [W-1:0]   sum_sat;
   logic signed [W-1:0]   delta;
   logic signed [W:0]     v_sum;
   logic signed [W-1:0]   v_next;
   logic signed [W:0]     ld_ext;
   logic signed [W-1:0]   ld_clamped;
   logic                  same;
   logic                  enter_settled;

   // Full-width accumulation cannot overflow; saturation happens afterwards.
   always_comb begin
      sum_raw = '0;
      for (int k = 0; k < N; k++) begin
         sum_raw = sum_raw + SW'($signed(i_flat[k*W +: W]));
      end
   end

   always_comb begin
      if (sum_raw > SUM_MAX) begin
         sum_sat = {1'b0, {(W-1){1'b1}}};
      end else if (sum_raw < SUM_MIN) begin
         sum_sat = {1'b1, {(W-1){1'b0}}};
      end else begin
         sum_sat = sum_raw[W-1:0];
      end
   end

   always_comb begin
      delta = sum_sat >>> CAP_SHIFT;
`ifdef NODE_LEAK_EN
      if (sum_raw == '0) begin
         if (v_q[W-1]) begin
            delta = W'(1);
         end else if (v_q != '0) begin
            delta = '1;
         end else begin
            delta = '0;
         end
      end
`endif
   end

   // One guard bit is enough: |v| and |delta| both fit in W signed bits.
   always_comb begin
      v_sum = {v_q[W-1], v_q} + {delta[W-1], delta};
      if (v_sum > V_HI) begin
         v_next = V_HI[W-1:0];
      end else if (v_sum < V_LO) begin
         v_next = V_LO[W-1:0];
      end else begin
         v_next = v_sum[W-1:0];
      end
   end

   always_comb begin
      ld_ext = {load_v[W-1], load_v};
      if (ld_ext > V_HI) begin
         ld_clamped = V_HI[W-1:0];
      end else if (ld_ext < V_LO) begin
         ld_clamped = V_LO[W-1:0];
      end else begin
         ld_clamped = load_v;
      end
   end

   assign same          = (v_next == v_q);
   assign enter_settled = same &&
                          (((state_q == S_RUN) && (Q_DONE == QW'(1))) ||
                           ((state_q == S_QUIET) && ((quiet_q + QW'(1)) == Q_DONE)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q       <= '0;
         state_q   <= S_RUN;
         quiet_q   <= '0;
         iter_q    <= '0;
         settled_q <= 1'b0;
         osc_q     <= 1'b0;
         changed_q <= 1'b0;
      end else if (load) begin
         v_q       <= ld_clamped;
         changed_q <= (ld_clamped != v_q);
         state_q   <= S_RUN;
         quiet_q   <= '0;
         iter_q    <= '0;
         settled_q <= 1'b0;
         osc_q     <= 1'b0;
      end else if (en) begin
         v_q       <= v_next;
         changed_q <= !same;
         case (state_q)
            S_RUN: begin
               if (same) begin
                  quiet_q <= QW'(1);
                  if (enter_settled) begin
                     state_q   <= S_SETTLED;
                     settled_q <= 1'b1;
                  end else begin
                     state_q <= S_QUIET;
                  end
               end
            end
            S_QUIET: begin
               if (same) begin
                  quiet_q <= quiet_q + QW'(1);
                  if (enter_settled) begin
                     state_q   <= S_SETTLED;
                     settled_q <= 1'b1;
                  end
               end else begin
                  state_q <= S_RUN;
                  quiet_q <= '0;
               end
            end
            S_SETTLED: begin
               if (!same) begin
                  state_q   <= S_RUN;
                  quiet_q   <= '0;
                  settled_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_RUN;
               quiet_q <= '0;
            end
         endcase
         // Settling restarts the convergence budget; a settled node never counts.
         if (enter_settled) begin
            iter_q <= '0;
         end else if ((state_q != S_SETTLED) && (iter_q != I_MAX)) begin
            iter_q <= iter_q + IW'(1);
            if ((iter_q + IW'(1)) == I_MAX) begin
               osc_q <= 1'b1;
            end
         end
      end else begin
         changed_q <= 1'b0;
      end
   end

   assign v         = v_q;
   assign level     = ~v_q[W-1];
   assign settled   = settled_q;
   assign osc       = osc_q;
   assign changed   = changed_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_node_integrator_sat.sv
// Directed bench for node_integrator_sat: a vector table plus hand-written ramp, oscillation, hold and reset sequences.
module tb_node_integrator_sat;

   localparam int W = 8;
   localparam int N = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                en;
   logic                load;
   logic signed [W-1:0] load_v;
   logic [N*W-1:0]      i_flat;
   logic signed [W-1:0] v;
   logic                level;
   logic                settled;
   logic                osc;
   logic                changed;
   logic [1:0]          dbg_state;

   int n_vec  = 0;
   int n_miss = 0;
   logic [W-1:0] exp_q[$];

   node_integrator_sat dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .load      (load),
      .load_v    (load_v),
      .i_flat    (i_flat),
      .v         (v),
      .level     (level),
      .settled   (settled),
      .osc       (osc),
      .changed   (changed),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      int          ldv;
      logic        en;
      logic [31:0] cur;
      int          ev;
      int          es;
      int          eo;
      int          ec;
   } vec_t;

   vec_t tbl[19];

   function automatic logic [31:0] cur(input int c0, input int c1, input int c2, input int c3);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(c0);
      b1 = 8'(c1);
      b2 = 8'(c2);
      b3 = 8'(c3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm, input int ev, input int es, input int eo, input int ec);
      check({nm, ".v"}, int'(v), ev);
      check({nm, ".level"}, int'(level), (ev >= 0) ? 1 : 0);
      check({nm, ".settled"}, int'(settled), es);
      check({nm, ".osc"}, int'(osc), eo);
      check({nm, ".changed"}, int'(changed), ec);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      en     = 1'b0;
      load   = 1'b0;
      load_v = '0;
      i_flat = '0;
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_load(input int val);
      load   = 1'b1;
      load_v = W'(val);
      tick();
      load   = 1'b0;
   endtask

   initial begin
      int ev;
      string nm;

      tbl[0]  = '{1'b1,  100, 1'b0, cur(0, 0, 0, 0),            64, 0, 0, 1};
      tbl[1]  = '{1'b1, -100, 1'b0, cur(0, 0, 0, 0),           -64, 0, 0, 1};
      tbl[2]  = '{1'b1,  -64, 1'b0, cur(0, 0, 0, 0),           -64, 0, 0, 0};
      tbl[3]  = '{1'b1,   10, 1'b0, cur(0, 0, 0, 0),            10, 0, 0, 1};
      tbl[4]  = '{1'b0,    0, 1'b1, cur(2, -3, 0, 0),            9, 0, 0, 1};
      tbl[5]  = '{1'b0,    0, 1'b1, cur(2, -3, 0, 0),            8, 0, 0, 1};
      tbl[6]  = '{1'b0,    0, 1'b0, cur(2, -3, 0, 0),            8, 0, 0, 0};
      tbl[7]  = '{1'b0,    0, 1'b1, cur(127, 127, 127, 127),    64, 0, 0, 1};
      tbl[8]  = '{1'b0,    0, 1'b1, cur(127, 127, 127, 127),    64, 0, 0, 0};
      tbl[9]  = '{1'b0,    0, 1'b1, cur(127, 127, 127, 127),    64, 0, 0, 0};
      tbl[10] = '{1'b0,    0, 1'b1, cur(127, 127, 127, 127),    64, 1, 0, 0};
      tbl[11] = '{1'b0,    0, 1'b1, cur(-128, -128, -128, -128), -64, 0, 0, 1};
      tbl[12] = '{1'b0,    0, 1'b1, cur(-1, 0, 0, 0),          -64, 0, 0, 0};
      tbl[13] = '{1'b0,    0, 1'b0, cur(-1, 0, 0, 0),          -64, 0, 0, 0};
      tbl[14] = '{1'b0,    0, 1'b1, cur(1, 0, 0, 0),           -63, 0, 0, 1};
      tbl[15] = '{1'b1,   -1, 1'b1, cur(1, 0, 0, 0),            -1, 0, 0, 1};
      tbl[16] = '{1'b0,    0, 1'b1, cur(1, 0, 0, 0),             0, 0, 0, 1};
      tbl[17] = '{1'b0,    0, 1'b1, cur(5, 3, -10, 4),           2, 0, 0, 1};
      tbl[18] = '{1'b0,    0, 1'b1, cur(127, 127, -128, -128),   0, 0, 0, 1};

      // Reset state, sampled while reset is held.
      rst_n  = 1'b0;
      en     = 1'b0;
      load   = 1'b0;
      load_v = '0;
      i_flat = '0;
      tick();
      check_all("reset", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors.
      for (int i = 0; i < 19; i++) begin
         load   = tbl[i].ld;
         load_v = W'(tbl[i].ldv);
         en     = tbl[i].en;
         i_flat = tbl[i].cur;
         tick();
         nm = $sformatf("vec%0d", i);
         check_all(nm, tbl[i].ev, tbl[i].es, tbl[i].eo, tbl[i].ec);
      end
      load = 1'b0;
      en   = 1'b0;

      // Sum saturation straight out of reset.
      do_reset();
      en     = 1'b1;
      i_flat = cur(127, 127, 127, 127);
      tick();
      check_all("sat1", 64, 0, 0, 1);
      tick();
      check_all("sat2", 64, 0, 0, 0);

      // Pullup ramp to the upper clamp, then settle on the third clamped cycle.
      do_reset();
      for (int k = 1; k <= 32; k++) exp_q.push_back(W'(2 * k));
      en     = 1'b1;
      i_flat = cur(2, 0, 0, 0);
      for (int k = 1; k <= 32; k++) begin
         tick();
         ev = int'($signed(exp_q.pop_front()));
         check($sformatf("ramp%0d.v", k), int'(v), ev);
         check($sformatf("ramp%0d.settled", k), int'(settled), 0);
      end
      tick();
      check_all("ramp_clamp1", 64, 0, 0, 0);
      tick();
      check_all("ramp_clamp2", 64, 0, 0, 0);
      tick();
      check_all("ramp_clamp3", 64, 1, 0, 0);
      for (int k = 0; k < 40; k++) tick();
      check_all("ramp_hold", 64, 1, 0, 0);

      // Fight to low: net -1 per cycle from 10 down to the lower clamp.
      do_load(10);
      i_flat = cur(2, -3, 0, 0);
      for (int k = 1; k <= 74; k++) begin
         tick();
         ev = (10 - k < -64) ? -64 : 10 - k;
         check($sformatf("fight%0d.v", k), int'(v), ev);
         check($sformatf("fight%0d.level", k), int'(level), (ev >= 0) ? 1 : 0);
      end

      // Oscillation: alternating current never settles; osc after 64 enabled cycles.
      do_load(0);
      for (int k = 0; k < 64; k++) begin
         i_flat = (k % 2 == 0) ? cur(2, 0, 0, 0) : cur(-2, 0, 0, 0);
         tick();
         check($sformatf("osc%0d.v", k), int'(v), (k % 2 == 0) ? 2 : 0);
         check($sformatf("osc%0d.settled", k), int'(settled), 0);
         check($sformatf("osc%0d.osc", k), int'(osc), (k == 63) ? 1 : 0);
      end
      en     = 1'b0;
      i_flat = cur(2, 0, 0, 0);
      for (int k = 0; k < 5; k++) tick();
      check_all("osc_freeze", 0, 0, 1, 0);
      do_load(0);
      check_all("osc_load_clear", 0, 0, 0, 0);

      // en=0 gaps freeze the iteration counter.
      for (int k = 0; k < 64; k++) begin
         en     = 1'b1;
         i_flat = (k % 2 == 0) ? cur(2, 0, 0, 0) : cur(-2, 0, 0, 0);
         tick();
         if (k == 39) begin
            en = 1'b0;
            for (int j = 0; j < 30; j++) tick();
            check("gap.osc", int'(osc), 0);
            check("gap.v", int'(v), 0);
         end
         if (k == 62) check("gap63.osc", int'(osc), 0);
      end
      check("gap64.osc", int'(osc), 1);

      // Asynchronous reset mid-operation.
      en     = 1'b1;
      i_flat = cur(2, 0, 0, 0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero current: ideal hold, or leak to 0 when leakage is built in.
      do_load(5);
      en     = 1'b1;
      i_flat = '0;
`ifdef NODE_LEAK_EN
      for (int k = 1; k <= 5; k++) begin
         tick();
         check_all($sformatf("leak%0d", k), 5 - k, 0, 0, 1);
      end
      tick();
      check_all("leak_q1", 0, 0, 0, 0);
      tick();
      check_all("leak_q2", 0, 0, 0, 0);
      tick();
      check_all("leak_q3", 0, 1, 0, 0);
`else
      tick();
      check_all("hold1", 5, 0, 0, 0);
      tick();
      check_all("hold2", 5, 0, 0, 0);
      tick();
      check_all("hold3", 5, 1, 0, 0);
`endif
      en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
